// File: rtl/drum_track_sr_if.sv
// Signal bundle for drum_track_sr: track controls in, serial taps, bit counter and word snapshot out.
// WVALID is a one-cycle strobe with no back-pressure; WORD holds its value until the next capture.
interface drum_track_sr_if #(
  parameter int LEN = 8,
  parameter int CH  = 1
);
  localparam int PW = $clog2(LEN);

  logic              HOLD;
  logic              ERASE;
  logic [CH-1:0]     WE;
  logic [CH-1:0]     A;
  logic [CH-1:0]     B;
  logic [CH-1:0]     Q;
  logic [CH-1:0]     _Q;
  logic [PW-1:0]     BITPOS;
  logic              WMARK;
  logic [CH*LEN-1:0] WORD;
  logic              WVALID;

  modport master (
    output HOLD, ERASE, WE, A, B,
    input  Q, _Q, BITPOS, WMARK, WORD, WVALID
  );

  modport slave (
    input  HOLD, ERASE, WE, A, B,
    output Q, _Q, BITPOS, WMARK, WORD, WVALID
  );
endinterface

// File: rtl/drum_track_sr.sv
// Recirculating serial track store: CH tracks of LEN bits sharing one bit-time counter,
// with gated serial write, erase, clock hold and a word snapshot taken at each word end.
module drum_track_sr #(
  parameter int LEN = 8,
  parameter int CH  = 1
) (
  input  logic           CLK,
  input  logic           CLR,
  drum_track_sr_if.slave bus
);
  localparam int            PW   = $clog2(LEN);
  localparam logic [PW-1:0] LAST = PW'(LEN - 1);

  if (LEN < 2) begin : g_len_check
    $error("drum_track_sr: LEN must be at least 2");
  end

  logic [CH-1:0][LEN-1:0] sr;
  logic [CH-1:0][LEN-1:0] sr_next;
  logic [CH-1:0]          din;
  logic [CH-1:0]          q;
  logic [PW-1:0]          bitpos;
  logic [CH*LEN-1:0]      word;
  logic                   wvalid;
  logic                   at_last;

  assign at_last = (bitpos == LAST);

  // Entering bit per track: erase wins, then gated write, else the tap recirculates.
  always_comb begin
    din     = '0;
    sr_next = sr;
    for (int c = 0; c < CH; c++) begin
      if (bus.ERASE) begin
        din[c] = 1'b0;
      end else if (bus.WE[c]) begin
        din[c] = bus.A[c] & bus.B[c];
      end else begin
        din[c] = sr[c][LEN-1];
      end
      sr_next[c] = {sr[c][LEN-2:0], din[c]};
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sr     <= '0;
      bitpos <= '0;
      word   <= '0;
      wvalid <= 1'b0;
    end else if (bus.HOLD) begin
      wvalid <= 1'b0;
    end else begin
      sr     <= sr_next;
      bitpos <= at_last ? '0 : bitpos + PW'(1);
      wvalid <= at_last;
      // Snapshot is post-shift so the bit entered at BITPOS 0 lands in the MSB.
      if (at_last) begin
        word <= sr_next;
      end
    end
  end

  always_comb begin
    q = '0;
    for (int c = 0; c < CH; c++) begin
      q[c] = sr[c][LEN-1];
    end
  end

  assign bus.Q      = q;
  assign bus._Q     = ~q;
  assign bus.BITPOS = bitpos;
  assign bus.WMARK  = at_last;
  assign bus.WORD   = word;
  assign bus.WVALID = wvalid;
endmodule
